// File: rtl/replay_buffer_dyn.sv
// Double-buffered replay buffer: captures a counted sequence from a valid/ready
// input and replays it rep times, with len/rep latched per sequence.
module replay_buffer_dyn #(
    parameter int MAX_LEN = 16,
    parameter int MAX_REP = 8,
    parameter int W       = 8,
    localparam int AW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
    localparam int LW     = $clog2(MAX_LEN + 1),
    localparam int RW     = $clog2(MAX_REP + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [LW-1:0] cfg_len,
    input  logic [RW-1:0] cfg_rep,
    input  logic [W-1:0]  idat,
    input  logic          ivld,
    output logic          irdy,
    output logic [W-1:0]  odat,
    output logic          olast,
    output logic          ofin,
    output logic          ovld,
    input  logic          ordy
);
    localparam int DEPTH = 2 ** (AW + 1);

    generate
        if (MAX_LEN < 1) begin : g_bad_len
            $error("replay_buffer_dyn: MAX_LEN must be >= 1");
        end
        if (MAX_REP < 1) begin : g_bad_rep
            $error("replay_buffer_dyn: MAX_REP must be >= 1");
        end
    endgenerate

    logic [W-1:0] mem [DEPTH];

    logic [1:0]         full_q, full_d;
    logic [1:0]         rfull_q, rfull_d;
    logic [1:0][LW-1:0] len_q, len_d;
    logic [1:0][RW-1:0] rep_q, rep_d;
    logic               wslot_q, wslot_d;
    logic               rslot_q, rslot_d;
    logic               wslot_vis_q, wslot_vis_d;
    logic [AW-1:0]      wcnt_q, wcnt_d;
    logic [AW-1:0]      wcnt_vis_q, wcnt_vis_d;
    logic [AW-1:0]      ridx_q, ridx_d;
    logic [RW-1:0]      rcnt_q, rcnt_d;
    logic               ovld_q, ovld_d;
    logic               olast_q, olast_d;
    logic               ofin_q, ofin_d;
    logic [W-1:0]       odat_q;

    logic          w_acc, w_last, rd, avail, rd_en, r_last, r_fin;
    logic [LW-1:0] len_san, wlen, rlen;
    logic [RW-1:0] rep_san, rrep;

    assign irdy  = rst_n && !full_q[wslot_q];
    assign odat  = odat_q;
    assign olast = olast_q;
    assign ofin  = ofin_q;
    assign ovld  = ovld_q;

    always_comb begin
        len_san = cfg_len;
        if (cfg_len == '0) begin
            len_san = LW'(1);
        end else if (cfg_len > LW'(MAX_LEN)) begin
            len_san = LW'(MAX_LEN);
        end
        rep_san = cfg_rep;
        if (cfg_rep == '0) begin
            rep_san = RW'(1);
        end else if (cfg_rep > RW'(MAX_REP)) begin
            rep_san = RW'(MAX_REP);
        end

        w_acc  = ivld && irdy;
        wlen   = (wcnt_q == '0) ? len_san : len_q[wslot_q];
        w_last = (LW'(wcnt_q) == wlen - LW'(1));

        rlen   = len_q[rslot_q];
        rrep   = rep_q[rslot_q];
        r_last = (LW'(ridx_q) == rlen - LW'(1));
        r_fin  = r_last && (rcnt_q == rrep - RW'(1));

        // Reader sees write progress one cycle late so the memory write has
        // landed before the registered read, giving a uniform two-edge latency.
        avail = rfull_q[rslot_q] ||
                ((rslot_q == wslot_vis_q) && (rcnt_q == '0) && (ridx_q < wcnt_vis_q));
        rd    = !ovld_q || ordy;
        rd_en = rd && avail;

        full_d      = full_q;
        rfull_d     = full_q;
        len_d       = len_q;
        rep_d       = rep_q;
        wslot_d     = wslot_q;
        rslot_d     = rslot_q;
        wslot_vis_d = wslot_q;
        wcnt_vis_d  = wcnt_q;
        wcnt_d      = wcnt_q;
        ridx_d      = ridx_q;
        rcnt_d      = rcnt_q;
        ovld_d      = ovld_q;
        olast_d     = olast_q;
        ofin_d      = ofin_q;

        if (w_acc) begin
            if (wcnt_q == '0) begin
                len_d[wslot_q] = len_san;
                rep_d[wslot_q] = rep_san;
            end
            if (w_last) begin
                full_d[wslot_q] = 1'b1;
                wslot_d         = !wslot_q;
                wcnt_d          = '0;
            end else begin
                wcnt_d = wcnt_q + AW'(1);
            end
        end

        if (rd) begin
            if (avail) begin
                ovld_d  = 1'b1;
                olast_d = r_last;
                ofin_d  = r_fin;
                if (r_fin) begin
                    full_d[rslot_q]  = 1'b0;
                    rfull_d[rslot_q] = 1'b0;
                    rslot_d          = !rslot_q;
                    ridx_d           = '0;
                    rcnt_d           = '0;
                end else if (r_last) begin
                    ridx_d = '0;
                    rcnt_d = rcnt_q + RW'(1);
                end else begin
                    ridx_d = ridx_q + AW'(1);
                end
            end else begin
                ovld_d  = 1'b0;
                olast_d = 1'b0;
                ofin_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= '0;
            rfull_q     <= '0;
            len_q       <= '0;
            rep_q       <= '0;
            wslot_q     <= 1'b0;
            rslot_q     <= 1'b0;
            wslot_vis_q <= 1'b0;
            wcnt_q      <= '0;
            wcnt_vis_q  <= '0;
            ridx_q      <= '0;
            rcnt_q      <= '0;
            ovld_q      <= 1'b0;
            olast_q     <= 1'b0;
            ofin_q      <= 1'b0;
        end else begin
            full_q      <= full_d;
            rfull_q     <= rfull_d;
            len_q       <= len_d;
            rep_q       <= rep_d;
            wslot_q     <= wslot_d;
            rslot_q     <= rslot_d;
            wslot_vis_q <= wslot_vis_d;
            wcnt_q      <= wcnt_d;
            wcnt_vis_q  <= wcnt_vis_d;
            ridx_q      <= ridx_d;
            rcnt_q      <= rcnt_d;
            ovld_q      <= ovld_d;
            olast_q     <= olast_d;
            ofin_q      <= ofin_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            mem[{wslot_q, wcnt_q}] <= idat;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            odat_q <= mem[{rslot_q, ridx_q}];
        end
    end
endmodule

// File: tb/tb_replay_buffer_dyn.sv
// Directed bench for replay_buffer_dyn: table of sequences with hand-computed
// sanitised len/rep, plus hand-written latency, overlap and reset sequences.
module tb_replay_buffer_dyn;
    localparam int MAX_LEN = 16;
    localparam int MAX_REP = 8;
    localparam int W       = 8;
    localparam int LW      = 5;
    localparam int RW      = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [LW-1:0] cfg_len = '0;
    logic [RW-1:0] cfg_rep = '0;
    logic [W-1:0]  idat = '0;
    logic          ivld = 1'b0;
    logic          irdy;
    logic [W-1:0]  odat;
    logic          olast, ofin, ovld;
    logic          ordy = 1'b1;

    replay_buffer_dyn #(.MAX_LEN(MAX_LEN), .MAX_REP(MAX_REP), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .cfg_rep(cfg_rep),
        .idat(idat), .ivld(ivld), .irdy(irdy), .odat(odat), .olast(olast),
        .ofin(ofin), .ovld(ovld), .ordy(ordy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cfg_len;
        int cfg_rep;
        int n_in;
        int base;
        int exp_len;
        int exp_rep;
        int rnd;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
        logic         f;
    } exp_t;

    exp_t   exp_q[$];
    int     xfer_cyc[$];
    int     n_cmp = 0;
    int     n_fail = 0;
    int     cyc = 0;
    int     out_n = 0;
    int     first_ovld = -1;
    int     acc_edge = -1;
    bit     rand_ordy = 1'b0;
    logic   ordy_fixed = 1'b1;
    bit     held = 1'b0;
    logic [W+1:0] held_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        ordy = rand_ordy ? 1'($urandom_range(0, 1)) : ordy_fixed;
    end

    // Output monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) chk("stall_hold", {ovld, olast, ofin, odat}, {1'b1, held_val});
            held     = ovld && !ordy;
            held_val = {olast, ofin, odat};
            if (ovld && first_ovld < 0) first_ovld = cyc;
            if (ovld && ordy) begin
                xfer_cyc.push_back(cyc);
                $display("out #%0d cyc=%0d data=%02h last=%0b fin=%0b", out_n, cyc, odat, olast, ofin);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out #%0d: got %02h expected nothing", out_n, odat);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("out_%0d", out_n), {odat, olast, ofin}, {e.d, e.l, e.f});
                end
                out_n++;
            end
        end
    end

    task automatic send_seq(input vec_t v, input bit keep_valid, output int stalls);
        int g;
        exp_t e;
        stalls = 0;
        for (int r = 0; r < v.exp_rep; r++) begin
            for (int j = 0; j < v.exp_len; j++) begin
                e.d = W'(v.base + j);
                e.l = (j == v.exp_len - 1);
                e.f = (j == v.exp_len - 1) && (r == v.exp_rep - 1);
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < v.n_in; i++) begin
            @(negedge clk);
            idat = W'(v.base + i);
            ivld = 1'b1;
            if (i == 0) begin
                cfg_len = LW'(v.cfg_len);
                cfg_rep = RW'(v.cfg_rep);
            end else begin
                cfg_len = LW'(i * 3 + 7);
                cfg_rep = RW'(i + 5);
            end
            g = 0;
            while (!irdy && g < 200) begin
                @(negedge clk);
                stalls++;
                g++;
            end
            if (!irdy) chk("irdy_timeout", irdy, 1);
            if (i == 0) acc_edge = cyc + 1;
            $display("in  cyc=%0d data=%02h cfg_len=%0d cfg_rep=%0d", cyc + 1, idat, cfg_len, cfg_rep);
            @(posedge clk);
        end
        if (!keep_valid) begin
            @(negedge clk);
            ivld = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int g = 0;
        while (exp_q.size() != 0 && g < 600) begin
            @(negedge clk);
            g++;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
        @(negedge clk);
        @(negedge clk);
        chk({name, "_idle_ovld"}, ovld, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        int st, st1, st2;
        tbl[0] = '{3, 2, 3, 'hA0, 3, 2, 0};
        tbl[1] = '{4, 3, 4, 'h10, 4, 3, 0};
        tbl[2] = '{2, 1, 2, 'h20, 2, 1, 0};
        tbl[3] = '{0, 0, 1, 'h55, 1, 1, 0};
        tbl[4] = '{21, 1, 16, 'h60, 16, 1, 0};
        tbl[5] = '{2, 15, 2, 'h80, 2, 8, 0};
        tbl[6] = '{5, 4, 5, 'hC0, 5, 4, 1};
        tbl[7] = '{4, 2, 2, 'hD0, 4, 2, 0};
        tbl[8] = '{2, 2, 2, 'hE0, 2, 2, 0};

        repeat (3) @(negedge clk);
        chk("rst_ovld", ovld, 0);
        chk("rst_olast", olast, 0);
        chk("rst_ofin", ofin, 0);
        chk("rst_irdy", irdy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("irdy_after_reset", irdy, 1);

        // Basic replay and first-output latency
        first_ovld = -1;
        send_seq(tbl[0], 1'b0, st);
        drain("t1");
        chk("t1_latency", first_ovld - acc_edge, 2);

        // Second sequence loads while the first replays, no bubble at switch
        xfer_cyc.delete();
        send_seq(tbl[1], 1'b1, st1);
        send_seq(tbl[2], 1'b0, st2);
        chk("t2_no_stall", st1 + st2, 0);
        chk("t2_overlap", exp_q.size() > 2, 1);
        chk("t2_both_full_irdy", irdy, 0);
        drain("t2");
        chk("t2_xfer_count", xfer_cyc.size(), 14);
        chk("t2_no_bubble", xfer_cyc[xfer_cyc.size() - 1] - xfer_cyc[0], 13);
        chk("t2_irdy_back", irdy, 1);

        // Sanitising corners and random backpressure
        for (int i = 3; i <= 6; i++) begin
            rand_ordy = (tbl[i].rnd != 0);
            send_seq(tbl[i], 1'b0, st);
            drain($sformatf("row%0d", i));
            rand_ordy = 1'b0;
        end

        // Asynchronous reset mid-sequence
        ordy_fixed = 1'b0;
        @(posedge clk);
        send_seq(tbl[7], 1'b0, st);
        repeat (3) @(negedge clk);
        chk("t5_pre_reset_ovld", ovld, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_reset_ovld", ovld, 0);
        chk("t5_reset_olast", olast, 0);
        chk("t5_reset_ofin", ofin, 0);
        chk("t5_reset_irdy", irdy, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ordy_fixed = 1'b1;
        send_seq(tbl[8], 1'b0, st);
        drain("t5_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
